// File: rtl/serial_out_dispatcher_if.sv
// Command handshake between the host command decoder and the dispatcher.
// The decoder drives one decoded command plus i_cmd_valid; the dispatcher
// answers with o_cmd_ready and captures the fields on the accepting edge.
interface serial_out_dispatcher_if #(
    parameter int DATA_BIT = 32,
    parameter int SEL_BIT  = 4
) ();
    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic [DATA_BIT-1:0] i_output_pattern;
    logic [DATA_BIT-1:0] i_freq_pattern;
    logic [SEL_BIT-1:0]  i_sel_out;
    logic                i_start;
    logic                i_stop;
    logic                i_mode;

    // Decoder side
    modport master (
        output i_cmd_valid, i_output_pattern, i_freq_pattern, i_sel_out,
               i_start, i_stop, i_mode,
        input  o_cmd_ready
    );

    // Dispatcher side
    modport slave (
        input  i_cmd_valid, i_output_pattern, i_freq_pattern, i_sel_out,
               i_start, i_stop, i_mode,
        output o_cmd_ready
    );
endinterface

// File: rtl/serial_out_dispatcher.sv
// Shares CH_NUM serial_out channels between decoded host commands.
// One command is handled at a time: it is checked against the channel range,
// a repeat-mode channel is stopped first, the dispatcher waits for the channel
// to go idle, loads the per-channel config and optionally issues a start pulse.
// All pulse outputs are decoded from the state register, so each lasts exactly
// one cycle and only the selected channel's bit can be high.
module serial_out_dispatcher #(
    parameter int DATA_BIT = 32,
    parameter int CH_NUM   = 4,
    parameter int SEL_BIT  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    serial_out_dispatcher_if.slave     cmd_if,
    input  logic [CH_NUM-1:0]          i_ch_busy,
    output logic [CH_NUM*DATA_BIT-1:0] o_ch_output_pattern,
    output logic [CH_NUM*DATA_BIT-1:0] o_ch_freq_pattern,
    output logic [CH_NUM-1:0]          o_ch_mode,
    output logic [CH_NUM-1:0]          o_ch_start,
    output logic [CH_NUM-1:0]          o_ch_stop,
    output logic                       o_update_done_tick,
    output logic                       o_err_sel_tick
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_STOP,
        S_WAIT,
        S_LOAD,
        S_START,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_reg, state_next;

    // Captured command fields
    logic [DATA_BIT-1:0] cmd_pat_reg;
    logic [DATA_BIT-1:0] cmd_freq_reg;
    logic [SEL_BIT-1:0]  cmd_sel_reg;
    logic                cmd_start_reg;
    logic                cmd_stop_reg;
    logic                cmd_mode_reg;

    logic                cmd_accept;
    logic [CH_NUM-1:0]   sel_hit;    // one-hot decode of the captured select
    logic                sel_valid;  // captured select addresses a real channel
    logic                busy_sel;   // busy flag of the selected channel
    logic                mode_sel;   // stored mode of the selected channel

    // Ready only in IDLE and never while reset is applied
    assign cmd_if.o_cmd_ready = (state_reg == S_IDLE) && !rst;
    assign cmd_accept         = cmd_if.i_cmd_valid && cmd_if.o_cmd_ready;

    // Out-of-range selects produce an all-zero decode, which doubles as the range check
    assign sel_valid = |sel_hit;
    assign busy_sel  = |(i_ch_busy & sel_hit);
    assign mode_sel  = |(o_ch_mode & sel_hit);

    // Capture the command fields on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_pat_reg   <= '0;
            cmd_freq_reg  <= '0;
            cmd_sel_reg   <= '0;
            cmd_start_reg <= 1'b0;
            cmd_stop_reg  <= 1'b0;
            cmd_mode_reg  <= 1'b0;
        end else if (cmd_accept) begin
            cmd_pat_reg   <= cmd_if.i_output_pattern;
            cmd_freq_reg  <= cmd_if.i_freq_pattern;
            cmd_sel_reg   <= cmd_if.i_sel_out;
            cmd_start_reg <= cmd_if.i_start;
            cmd_stop_reg  <= cmd_if.i_stop;
            cmd_mode_reg  <= cmd_if.i_mode;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; stop takes priority over start, a repeat-mode busy
    // channel is stopped before waiting, a one-shot busy channel is just awaited
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_accept) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (!sel_valid)               state_next = S_ERR;
                else if (cmd_stop_reg)        state_next = S_STOP;
                else if (busy_sel && mode_sel) state_next = S_STOP;
                else if (busy_sel)            state_next = S_WAIT;
                else                          state_next = S_LOAD;
            end
            S_STOP: begin
                state_next = cmd_stop_reg ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (!busy_sel) state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = cmd_start_reg ? S_START : S_DONE;
            end
            S_START: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Moore pulse outputs decoded from the state register
    assign o_ch_stop          = (state_reg == S_STOP)  ? sel_hit : '0;
    assign o_ch_start         = (state_reg == S_START) ? sel_hit : '0;
    assign o_update_done_tick = (state_reg == S_DONE);
    assign o_err_sel_tick     = (state_reg == S_ERR);

    // Per-channel config registers, written only in LOAD for the selected channel
    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic [DATA_BIT-1:0] ch_pat_reg;
            logic [DATA_BIT-1:0] ch_freq_reg;
            logic                ch_mode_reg;

            assign sel_hit[gi] = (cmd_sel_reg == SEL_BIT'(gi));

            // Load this channel's config when it is the LOAD target
            always_ff @(posedge clk) begin
                if (rst) begin
                    ch_pat_reg  <= '0;
                    ch_freq_reg <= '0;
                    ch_mode_reg <= 1'b0;
                end else if ((state_reg == S_LOAD) && sel_hit[gi]) begin
                    ch_pat_reg  <= cmd_pat_reg;
                    ch_freq_reg <= cmd_freq_reg;
                    ch_mode_reg <= cmd_mode_reg;
                end
            end

            assign o_ch_output_pattern[gi*DATA_BIT +: DATA_BIT] = ch_pat_reg;
            assign o_ch_freq_pattern[gi*DATA_BIT +: DATA_BIT]   = ch_freq_reg;
            assign o_ch_mode[gi]                                = ch_mode_reg;
        end
    endgenerate

endmodule
